// File: rtl/sisc_exec_core.sv
// SISC execution core: multicycle control FSM, ALU and write-back mux.
// Register file and status register live outside this block.
module sisc_exec_core (
    input  logic        clk,
    input  logic        rst_f,
    input  logic [31:0] ir,
    input  logic [31:0] rsa,
    input  logic [31:0] rsb,
    input  logic [3:0]  stat_in,
    input  logic [31:0] mem_data,
    output logic        rf_we,
    output logic        wb_sel,
    output logic [1:0]  alu_op,
    output logic [31:0] alu_result,
    output logic [31:0] rf_write_data,
    output logic [3:0]  stat_out,
    output logic        stat_en,
    output logic        halt
);

    typedef enum logic [2:0] {
        START0, START1, FETCH, DECODE,
        EXECUTE, MEM, WRITEBACK, HALT
    } state_t;

    localparam logic [3:0] OP_REG = 4'b0001;
    localparam logic [3:0] OP_IMM = 4'b0010;
    localparam logic [3:0] OP_HLT = 4'b1111;

    state_t      state, nxt;
    logic [31:0] ir_q;
    logic [3:0]  opc;
    logic        is_alu;
    logic [1:0]  mode;

    assign opc    = ir_q[31:28];
    assign is_alu = (opc == OP_REG) || (opc == OP_IMM);
    assign mode   = (opc == OP_IMM) ? 2'b10 : 2'b01;

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state <= START0;
            ir_q  <= '0;
        end else begin
            state <= nxt;
            if (state == FETCH)
                ir_q <= ir;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            START0:    nxt = START1;
            START1:    nxt = FETCH;
            FETCH:     nxt = DECODE;
            DECODE:    nxt = (opc == OP_HLT) ? HALT : EXECUTE;
            EXECUTE:   nxt = MEM;
            MEM:       nxt = WRITEBACK;
            WRITEBACK: nxt = FETCH;
            HALT:      nxt = HALT;
        endcase
    end

    always_comb begin
        rf_we   = 1'b0;
        wb_sel  = 1'b0;
        alu_op  = 2'b00;
        stat_en = 1'b0;
        halt    = 1'b0;
        unique case (1'b1)
            (state == EXECUTE): begin
                alu_op  = is_alu ? mode : 2'b00;
                stat_en = is_alu;
            end
            (state == MEM): begin
                alu_op = is_alu ? mode : 2'b00;
            end
            (state == WRITEBACK): begin
                alu_op = is_alu ? mode : 2'b00;
                rf_we  = is_alu;
            end
            (state == HALT): halt = 1'b1;
            default: ;
        endcase
    end

    logic [31:0] op_b;
    logic [32:0] sum;
    logic [31:0] res;
    logic        c_f, v_f;

    assign op_b = (alu_op == 2'b10) ? {{16{ir_q[15]}}, ir_q[15:0]} : rsb;

    always_comb begin
        sum = '0;
        res = '0;
        c_f = 1'b0;
        v_f = 1'b0;
        unique case (ir_q[27:24])
            4'd0: begin
                sum = {1'b0, rsa} + {1'b0, op_b};
                res = sum[31:0];
                c_f = sum[32];
                v_f = (rsa[31] == op_b[31]) && (res[31] != rsa[31]);
            end
            4'd1: begin
                res = rsa - op_b;
                c_f = (rsa >= op_b);
                v_f = (rsa[31] != op_b[31]) && (res[31] != rsa[31]);
            end
            4'd2:    res = rsa & op_b;
            4'd3:    res = rsa | op_b;
            4'd4:    res = rsa ^ op_b;
            4'd5:    res = ~rsa;
            4'd6:    res = rsa << op_b[4:0];
            4'd7:    res = rsa >> op_b[4:0];
            default: res = op_b;
        endcase
    end

    // Idle and reserved operand modes force result and flags to zero.
    always_comb begin
        alu_result = '0;
        stat_out   = '0;
        if (alu_op == 2'b01 || alu_op == 2'b10) begin
            alu_result = res;
            stat_out   = {c_f, res[31], v_f, (res == 32'd0)};
        end
    end

    assign rf_write_data = wb_sel ? mem_data : alu_result;

    logic unused_bits;
    assign unused_bits = ^{stat_in, ir_q[23:16]};

endmodule

// File: tb/tb_sisc_exec_core.sv
// Bench for sisc_exec_core: per-cycle control checks plus a scoreboard
// of ALU results matched against stat_en / rf_we pulses.
module tb_sisc_exec_core;

    logic        clk = 1'b0;
    logic        rst_f;
    logic [31:0] ir, rsa, rsb, mem_data;
    logic [3:0]  stat_in;
    logic        rf_we, wb_sel, stat_en, halt;
    logic [1:0]  alu_op;
    logic [31:0] alu_result, rf_write_data;
    logic [3:0]  stat_out;

    sisc_exec_core dut (
        .clk           (clk),
        .rst_f         (rst_f),
        .ir            (ir),
        .rsa           (rsa),
        .rsb           (rsb),
        .stat_in       (stat_in),
        .mem_data      (mem_data),
        .rf_we         (rf_we),
        .wb_sel        (wb_sel),
        .alu_op        (alu_op),
        .alu_result    (alu_result),
        .rf_write_data (rf_write_data),
        .stat_out      (stat_out),
        .stat_en       (stat_en),
        .halt          (halt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  op;
        logic [3:0]  fl;
        logic [31:0] res;
    } ex_t;

    ex_t         sb_ex[$];
    logic [31:0] sb_wb[$];
    int          n_chk  = 0;
    int          n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [35:0] model(input logic [3:0] mm,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [32:0] w;
        logic [31:0] r;
        logic        c, v;
        c = 1'b0;
        v = 1'b0;
        case (mm)
            4'd0: begin
                w = {1'b0, a} + {1'b0, b};
                r = w[31:0];
                c = w[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'd1: begin
                r = a - b;
                c = (a >= b);
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            4'd2:    r = a & b;
            4'd3:    r = a | b;
            4'd4:    r = a ^ b;
            4'd5:    r = ~a;
            4'd6:    r = a << b[4:0];
            4'd7:    r = a >> b[4:0];
            default: r = b;
        endcase
        return {c, r[31], v, (r == 32'd0), r};
    endfunction

    // Scoreboard side: data is matched whenever the DUT pulses.
    always @(negedge clk) begin
        if (rst_f === 1'b1) begin
            if (stat_en) begin
                if (sb_ex.size() == 0) begin
                    chk("ex_unexpected", 1, 0);
                end else begin
                    ex_t e;
                    e = sb_ex.pop_front();
                    chk("alu_result", alu_result, e.res);
                    chk("stat_out", {28'd0, stat_out}, {28'd0, e.fl});
                    chk("ex_alu_op", {30'd0, alu_op}, {30'd0, e.op});
                end
            end
            if (rf_we) begin
                if (sb_wb.size() == 0) begin
                    chk("wb_unexpected", 1, 0);
                end else begin
                    chk("rf_write_data", rf_write_data, sb_wb.pop_front());
                    chk("wb_sel", {31'd0, wb_sel}, 0);
                end
            end
        end
    end

    task automatic idle_chk(input string tag);
        chk({tag, "_rf_we"}, {31'd0, rf_we}, 0);
        chk({tag, "_wb_sel"}, {31'd0, wb_sel}, 0);
        chk({tag, "_alu_op"}, {30'd0, alu_op}, 0);
        chk({tag, "_stat_en"}, {31'd0, stat_en}, 0);
        chk({tag, "_alu_result"}, alu_result, 0);
        chk({tag, "_stat_out"}, {28'd0, stat_out}, 0);
        chk({tag, "_rf_wdata"}, rf_write_data, 0);
    endtask

    // Called at the negedge of a FETCH cycle; returns at the next FETCH.
    task automatic issue(input logic [31:0] iv, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] md);
        logic [3:0]  opc;
        logic        vld;
        logic [1:0]  md_op;
        logic [31:0] bop;
        logic [35:0] e;
        opc   = iv[31:28];
        vld   = (opc == 4'b0001) || (opc == 4'b0010);
        md_op = (opc == 4'b0010) ? 2'b10 : 2'b01;
        bop   = (md_op == 2'b10) ? {{16{iv[15]}}, iv[15:0]} : b;
        ir = iv;
        rsa = a;
        rsb = b;
        mem_data = md;
        if (vld) begin
            e = model(iv[27:24], a, bop);
            sb_ex.push_back({md_op, e[35:32], e[31:0]});
            sb_wb.push_back(e[31:0]);
        end
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1)
                ir = $urandom;
            chk("alu_op", {30'd0, alu_op},
                {30'd0, (vld && k >= 2 && k <= 4) ? md_op : 2'b00});
            chk("stat_en", {31'd0, stat_en}, {31'd0, vld && k == 2});
            chk("rf_we", {31'd0, rf_we}, {31'd0, vld && k == 4});
            chk("halt", {31'd0, halt}, 0);
            if (!vld && k == 2)
                chk("noop_result", alu_result, 0);
        end
    endtask

    task automatic do_reset(input string tag);
        #2 rst_f = 1'b0;
        #1 chk({tag, "_halt_async"}, {31'd0, halt}, 0);
        mem_data = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            idle_chk(tag);
            chk({tag, "_halt"}, {31'd0, halt}, 0);
        end
        rst_f = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            idle_chk({tag, "_start"});
        end
    endtask

    initial begin
        rst_f    = 1'b0;
        ir       = 32'h1012_0000;
        rsa      = 32'd5;
        rsb      = 32'd7;
        stat_in  = 4'hF;
        mem_data = '0;
        @(negedge clk);
        do_reset("rst");

        issue(32'h1012_0000, 32'd5, 32'd7, 32'h0);
        issue(32'h1112_0000, 32'd3, 32'd3, 32'h0);
        issue(32'h1012_0000, 32'h7FFF_FFFF, 32'd1, 32'h0);
        issue(32'h2012_FFFF, 32'd10, 32'h0000_1234, 32'h0);
        issue(32'h1112_0000, 32'd2, 32'd5, 32'hDEAD_BEEF);
        for (int m = 2; m < 10; m++)
            issue({4'b0001, m[3:0], 24'h120000}, $urandom, $urandom,
                  32'hDEAD_BEEF);
        issue(32'h2412_8001, $urandom, $urandom, 32'hDEAD_BEEF);
        issue(32'h5012_0000, 32'd5, 32'd7, 32'hDEAD_BEEF);
        issue(32'h0000_0000, 32'd5, 32'd7, 32'h0);

        // Abort an add after its EXECUTE cycle; no write-back may follow.
        ir  = 32'h1012_0000;
        rsa = 32'd20;
        rsb = 32'd22;
        sb_ex.push_back({2'b01, 4'b0000, 32'd42});
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        do_reset("abort");
        issue(32'h1012_0000, 32'd1, 32'd2, 32'h0);

        ir = 32'hF000_0000;
        @(negedge clk);
        chk("hlt_decode_halt", {31'd0, halt}, 0);
        for (int i = 0; i < 20; i++) begin
            ir  = {4'b0001, 28'($urandom)};
            rsa = $urandom;
            @(negedge clk);
            chk("halt_held", {31'd0, halt}, 1);
            idle_chk("halted");
        end
        do_reset("unhalt");
        issue(32'h1012_0000, 32'd100, 32'd23, 32'h0);

        chk("sb_ex_drain", sb_ex.size(), 0);
        chk("sb_wb_drain", sb_wb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
